// File: rtl/cpu301_pkg.sv
// Shared definitions for the 301 16-bit RISC CPU: datapath width, trace depth default,
// control-word field widths and the branch-offset sign extension.
package cpu301_pkg;
  localparam int DW                  = 16;
  localparam int TRACE_DEPTH_DEFAULT = 8;
  localparam int CTRL_W              = 1;   // every PC/IR control-word field is one bit
  localparam int OFFSET_W            = 8;   // branch offset lives in IR[7:0]

  function automatic logic [DW-1:0] sext8(input logic [OFFSET_W-1:0] v);
    return {{(DW-OFFSET_W){v[OFFSET_W-1]}}, v};
  endfunction
endpackage

// File: rtl/fetch_unit_if.sv
// Bus between the control unit / datapath and the fetch stage.
interface fetch_if
  import cpu301_pkg::*;
#(
  parameter int TRACE_DEPTH = TRACE_DEPTH_DEFAULT
);
  logic [CTRL_W-1:0]              pc_ld;
  logic [CTRL_W-1:0]              pc_inc;
  logic [CTRL_W-1:0]              pc_sel;
  logic [CTRL_W-1:0]              ir_ld;
  logic [CTRL_W-1:0]              adr_sel;
  logic [DW-1:0]                  mem_dout;
  logic [DW-1:0]                  reg_r;
  logic [DW-1:0]                  reg_s;
  logic                           trc_rd;
  logic [DW-1:0]                  IR;
  logic [DW-1:0]                  PC;
  logic [DW-1:0]                  mem_adr;
  logic [DW-1:0]                  instr_cnt;
  logic [DW-1:0]                  trc_dout;
  logic [$clog2(TRACE_DEPTH):0]   trc_count;
  logic                           trc_ovf;

  // Handshake: trc_rd is a pop request taken on any edge where trc_count is nonzero;
  // trc_dout is valid (the oldest entry) whenever trc_count is nonzero and reads 0 otherwise.
  modport master (
    output pc_ld, pc_inc, pc_sel, ir_ld, adr_sel, mem_dout, reg_r, reg_s, trc_rd,
    input  IR, PC, mem_adr, instr_cnt, trc_dout, trc_count, trc_ovf
  );
  modport slave (
    input  pc_ld, pc_inc, pc_sel, ir_ld, adr_sel, mem_dout, reg_r, reg_s, trc_rd,
    output IR, PC, mem_adr, instr_cnt, trc_dout, trc_count, trc_ovf
  );
endinterface

// File: rtl/fetch_unit_trace_fifo.sv
// Circular trace buffer: show-ahead read, overwrites the oldest entry when full
// and raises a sticky overflow flag.
module trace_fifo #(
  parameter int DW    = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [DW-1:0]            push_data,
  input  logic                     pop,
  output logic [DW-1:0]            dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_q;
  logic          ovf_q;
  logic          pop_ok;
  logic          full;

  assign pop_ok = pop && (count_q != '0);
  assign full   = (count_q == FULL_CNT);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      // A push into a full buffer without a pop drops the oldest entry.
      if (pop_ok || (push && full)) rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop_ok && !full) count_q <= count_q + (AW+1)'(1);
      else if (!push && pop_ok)     count_q <= count_q - (AW+1)'(1);
      if (push && full && !pop_ok) ovf_q <= 1'b1;
    end
  end

  assign dout  = (count_q == '0) ? '0 : mem[rd_ptr];
  assign count = count_q;
  assign ovf   = ovf_q;
endmodule

// File: rtl/fetch_unit.sv
// PC / IR stage of the 301 CPU with a saturating instruction counter and a trace
// buffer that records every taken PC load target.
module fetch_unit
  import cpu301_pkg::*;
#(
  parameter int TRACE_DEPTH = TRACE_DEPTH_DEFAULT
) (
  input  logic   clk,
  input  logic   reset_n,
  fetch_if.slave bus
);
  logic [DW-1:0] pc_q;
  logic [DW-1:0] ir_q;
  logic [DW-1:0] cnt_q;
  logic [DW-1:0] pc_target;

  // Relative branches add to the already-incremented PC, using the IR currently held.
  assign pc_target = bus.pc_sel[0] ? bus.reg_s : pc_q + sext8(ir_q[OFFSET_W-1:0]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q  <= '0;
      ir_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (bus.pc_ld[0])       pc_q <= pc_target;
      else if (bus.pc_inc[0]) pc_q <= pc_q + DW'(1);
      if (bus.ir_ld[0]) begin
        ir_q <= bus.mem_dout;
        if (cnt_q != '1) cnt_q <= cnt_q + DW'(1);
      end
    end
  end

  trace_fifo #(
    .DW    (DW),
    .DEPTH (TRACE_DEPTH)
  ) u_trace (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (bus.pc_ld[0]),
    .push_data (pc_target),
    .pop       (bus.trc_rd),
    .dout      (bus.trc_dout),
    .count     (bus.trc_count),
    .ovf       (bus.trc_ovf)
  );

  assign bus.PC        = pc_q;
  assign bus.IR        = ir_q;
  assign bus.instr_cnt = cnt_q;
  assign bus.mem_adr   = bus.adr_sel[0] ? bus.reg_r : pc_q;
endmodule
